// File: rtl/memory_stage_pkg.sv
// memory_stage_pkg
//   Shared constants for the MIPS MEM stage: opcode/funct widths, the
//   LOAD/STORE opcodes that select a data-memory access, and the MEM-stage
//   FSM state encoding.
package memory_stage_pkg;

   localparam int OPCODE_WIDTH = 6;
   localparam int FUNCT_WIDTH  = 6;

   // Word load/store opcodes (lw / sw)
   localparam logic [OPCODE_WIDTH-1:0] LOAD  = 6'b100011;
   localparam logic [OPCODE_WIDTH-1:0] STORE = 6'b101011;
   localparam logic [OPCODE_WIDTH-1:0] RTYPE = 6'b000000;

   typedef enum logic {
      MS_IDLE = 1'b0,
      MS_WAIT = 1'b1
   } ms_state_e;

   function automatic logic is_mem_op(input logic [OPCODE_WIDTH-1:0] op);
      return (op == LOAD) || (op == STORE);
   endfunction

endpackage

// File: rtl/memory_stage.sv
// memory_stage
//   MIPS pipeline MEM stage. Takes the execute stage's registered result
//   bus, performs aligned word loads/stores over a req/ack memory port and
//   forwards the result (plus load data) to writeback.
//
// Ports
//   es_clk / es_rst        clock, async active-low reset
//   ms_i_*  (pipeline)     ce, opcode, funct, alu_value (EA), zero, data_rt, rd_addr
//   ms_o_mem_* / ms_i_mem_* data-memory request/response port
//   ms_o_* (writeback)     data, alu_value, opcode, funct, rd_addr, zero, ce
//   ms_o_stall             hold execute while an access is outstanding
//   ms_o_err               one-cycle pulse: misaligned access or ack timeout
module memory_stage
   import memory_stage_pkg::*;
#(
   parameter int DWIDTH   = 32,
   parameter int MAX_WAIT = 16
) (
   input  logic                    es_clk,
   input  logic                    es_rst,
   input  logic                    ms_i_ce,
   input  logic [OPCODE_WIDTH-1:0] ms_i_opcode,
   input  logic [FUNCT_WIDTH-1:0]  ms_i_funct,
   input  logic [DWIDTH-1:0]       ms_i_alu_value,
   input  logic                    ms_i_zero,
   input  logic [DWIDTH-1:0]       ms_i_data_rt,
   input  logic [4:0]              ms_i_rd_addr,
   output logic                    ms_o_mem_req,
   output logic                    ms_o_mem_we,
   output logic [DWIDTH-1:0]       ms_o_mem_addr,
   output logic [DWIDTH-1:0]       ms_o_mem_wdata,
   input  logic                    ms_i_mem_ack,
   input  logic [DWIDTH-1:0]       ms_i_mem_rdata,
   output logic [DWIDTH-1:0]       ms_o_data,
   output logic [DWIDTH-1:0]       ms_o_alu_value,
   output logic [OPCODE_WIDTH-1:0] ms_o_opcode,
   output logic [FUNCT_WIDTH-1:0]  ms_o_funct,
   output logic [4:0]              ms_o_rd_addr,
   output logic                    ms_o_zero,
   output logic                    ms_o_ce,
   output logic                    ms_o_stall,
   output logic                    ms_o_err
);

   localparam int CW = $clog2(MAX_WAIT) + 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(MAX_WAIT - 1);

   ms_state_e                r_state, w_state;
   logic [CW-1:0]            r_cnt, w_cnt;
   logic                     r_req, w_req;
   logic                     r_we, w_we;
   logic [DWIDTH-1:0]        r_addr, w_addr;
   logic [DWIDTH-1:0]        r_wdata, w_wdata;
   logic [DWIDTH-1:0]        r_data, w_data;
   logic [DWIDTH-1:0]        r_alu, w_alu;
   logic [OPCODE_WIDTH-1:0]  r_opcode, w_opcode;
   logic [FUNCT_WIDTH-1:0]   r_funct, w_funct;
   logic [4:0]               r_rd, w_rd;
   logic                     r_zero, w_zero;
   logic                     r_ce, w_ce;
   logic                     r_err, w_err;

   logic                     w_is_mem, w_is_store, w_misal;

   assign w_is_mem   = is_mem_op(ms_i_opcode);
   assign w_is_store = (ms_i_opcode == STORE);
   assign w_misal    = (ms_i_alu_value[1:0] != 2'b00);

   always_comb begin
      w_state  = r_state;
      w_cnt    = r_cnt;
      w_req    = r_req;
      w_we     = r_we;
      w_addr   = r_addr;
      w_wdata  = r_wdata;
      w_data   = r_data;
      w_alu    = r_alu;
      w_opcode = r_opcode;
      w_funct  = r_funct;
      w_rd     = r_rd;
      w_zero   = r_zero;
      w_ce     = 1'b0;
      w_err    = 1'b0;
      case (r_state)
         MS_IDLE: begin
            if (ms_i_ce) begin
               w_alu    = ms_i_alu_value;
               w_opcode = ms_i_opcode;
               w_funct  = ms_i_funct;
               w_rd     = ms_i_rd_addr;
               w_zero   = ms_i_zero;
               w_data   = '0;
               if (w_is_mem && w_misal) begin
                  w_err = 1'b1;           // no bus request on misalignment
               end else if (w_is_mem) begin
                  w_state = MS_WAIT;
                  w_req   = 1'b1;
                  w_we    = w_is_store;
                  w_addr  = ms_i_alu_value;
                  w_wdata = w_is_store ? ms_i_data_rt : '0;
                  w_cnt   = '0;
               end else begin
                  w_ce = 1'b1;
               end
            end else begin
               // bubble: clear result/data, keep control fields for writeback
               w_data = '0;
               w_alu  = '0;
            end
         end
         MS_WAIT: begin
            // pipeline inputs are ignored here; execute is stalled
            if (ms_i_mem_ack) begin        // ack wins over timeout
               w_state = MS_IDLE;
               w_req   = 1'b0;
               w_we    = 1'b0;
               w_addr  = '0;
               w_wdata = '0;
               w_ce    = 1'b1;
               w_data  = r_we ? '0 : ms_i_mem_rdata;
            end else if (r_cnt == CNT_LAST) begin
               w_state = MS_IDLE;
               w_req   = 1'b0;
               w_we    = 1'b0;
               w_addr  = '0;
               w_wdata = '0;
               w_err   = 1'b1;
               w_data  = '0;
            end else begin
               w_cnt = r_cnt + 1'b1;
            end
         end
         default: w_state = MS_IDLE;
      endcase
   end

   always_ff @(posedge es_clk or negedge es_rst) begin
      if (!es_rst) begin
         r_state  <= MS_IDLE;
         r_cnt    <= '0;
         r_req    <= 1'b0;
         r_we     <= 1'b0;
         r_addr   <= '0;
         r_wdata  <= '0;
         r_data   <= '0;
         r_alu    <= '0;
         r_opcode <= '0;
         r_funct  <= '0;
         r_rd     <= '0;
         r_zero   <= 1'b0;
         r_ce     <= 1'b0;
         r_err    <= 1'b0;
      end else begin
         r_state  <= w_state;
         r_cnt    <= w_cnt;
         r_req    <= w_req;
         r_we     <= w_we;
         r_addr   <= w_addr;
         r_wdata  <= w_wdata;
         r_data   <= w_data;
         r_alu    <= w_alu;
         r_opcode <= w_opcode;
         r_funct  <= w_funct;
         r_rd     <= w_rd;
         r_zero   <= w_zero;
         r_ce     <= w_ce;
         r_err    <= w_err;
      end
   end

   assign ms_o_stall     = (r_state == MS_WAIT);
   assign ms_o_mem_req   = r_req;
   assign ms_o_mem_we    = r_we;
   assign ms_o_mem_addr  = r_addr;
   assign ms_o_mem_wdata = r_wdata;
   assign ms_o_data      = r_data;
   assign ms_o_alu_value = r_alu;
   assign ms_o_opcode    = r_opcode;
   assign ms_o_funct     = r_funct;
   assign ms_o_rd_addr   = r_rd;
   assign ms_o_zero      = r_zero;
   assign ms_o_ce        = r_ce;
   assign ms_o_err       = r_err;

endmodule

// File: tb/tb_memory_stage.sv
// tb_memory_stage
//   Directed plus randomized bench for memory_stage (MAX_WAIT=4). Each
//   instruction's outcome is predicted from the stage's rules: non-memory ops
//   complete next cycle, misaligned accesses pulse err, aligned accesses hold
//   the bus until ack (or abort after MAX_WAIT waiting cycles).
module tb_memory_stage;
   import memory_stage_pkg::*;

   localparam int DW   = 32;
   localparam int MAXW = 4;

   logic                    es_clk = 1'b0;
   logic                    es_rst;
   logic                    ms_i_ce;
   logic [OPCODE_WIDTH-1:0] ms_i_opcode;
   logic [FUNCT_WIDTH-1:0]  ms_i_funct;
   logic [DW-1:0]           ms_i_alu_value;
   logic                    ms_i_zero;
   logic [DW-1:0]           ms_i_data_rt;
   logic [4:0]              ms_i_rd_addr;
   logic                    ms_o_mem_req;
   logic                    ms_o_mem_we;
   logic [DW-1:0]           ms_o_mem_addr;
   logic [DW-1:0]           ms_o_mem_wdata;
   logic                    ms_i_mem_ack;
   logic [DW-1:0]           ms_i_mem_rdata;
   logic [DW-1:0]           ms_o_data;
   logic [DW-1:0]           ms_o_alu_value;
   logic [OPCODE_WIDTH-1:0] ms_o_opcode;
   logic [FUNCT_WIDTH-1:0]  ms_o_funct;
   logic [4:0]              ms_o_rd_addr;
   logic                    ms_o_zero;
   logic                    ms_o_ce;
   logic                    ms_o_stall;
   logic                    ms_o_err;

   int total = 0;
   int bad   = 0;

   // model of the held writeback control fields
   logic [OPCODE_WIDTH-1:0] m_op;
   logic [FUNCT_WIDTH-1:0]  m_fn;
   logic [4:0]              m_rd;
   logic                    m_zero;

   always #5 es_clk = ~es_clk;

   memory_stage #(.DWIDTH(DW), .MAX_WAIT(MAXW)) dut (
      .es_clk(es_clk), .es_rst(es_rst),
      .ms_i_ce(ms_i_ce), .ms_i_opcode(ms_i_opcode), .ms_i_funct(ms_i_funct),
      .ms_i_alu_value(ms_i_alu_value), .ms_i_zero(ms_i_zero),
      .ms_i_data_rt(ms_i_data_rt), .ms_i_rd_addr(ms_i_rd_addr),
      .ms_o_mem_req(ms_o_mem_req), .ms_o_mem_we(ms_o_mem_we),
      .ms_o_mem_addr(ms_o_mem_addr), .ms_o_mem_wdata(ms_o_mem_wdata),
      .ms_i_mem_ack(ms_i_mem_ack), .ms_i_mem_rdata(ms_i_mem_rdata),
      .ms_o_data(ms_o_data), .ms_o_alu_value(ms_o_alu_value),
      .ms_o_opcode(ms_o_opcode), .ms_o_funct(ms_o_funct),
      .ms_o_rd_addr(ms_o_rd_addr), .ms_o_zero(ms_o_zero),
      .ms_o_ce(ms_o_ce), .ms_o_stall(ms_o_stall), .ms_o_err(ms_o_err)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
      end
   endtask

   task automatic check_fields(input string tag, input logic [31:0] alu);
      check({tag, "_alu"},    ms_o_alu_value, alu);
      check({tag, "_opcode"}, 32'(ms_o_opcode), 32'(m_op));
      check({tag, "_funct"},  32'(ms_o_funct),  32'(m_fn));
      check({tag, "_rd"},     32'(ms_o_rd_addr), 32'(m_rd));
      check({tag, "_zero"},   32'(ms_o_zero),    32'(m_zero));
   endtask

   task automatic garbage_inputs();
      ms_i_ce        = 1'($urandom);
      ms_i_opcode    = 6'($urandom);
      ms_i_funct     = 6'($urandom);
      ms_i_alu_value = $urandom;
      ms_i_zero      = 1'($urandom);
      ms_i_data_rt   = $urandom;
      ms_i_rd_addr   = 5'($urandom);
   endtask

   // Idle (ce=0) cycle; optionally a stray ack, which must be ignored.
   task automatic idle_cycle(input bit stray_ack);
      garbage_inputs();
      ms_i_ce        = 1'b0;
      ms_i_mem_ack   = stray_ack;
      ms_i_mem_rdata = $urandom;
      @(posedge es_clk); @(negedge es_clk);
      ms_i_mem_ack = 1'b0;
      check("idle_ce",    32'(ms_o_ce), 0);
      check("idle_err",   32'(ms_o_err), 0);
      check("idle_data",  ms_o_data, 0);
      check("idle_req",   32'(ms_o_mem_req), 0);
      check("idle_stall", 32'(ms_o_stall), 0);
      check_fields("idle", 32'h0);
   endtask

   // Issue one instruction at a negedge in IDLE; ack_dly = index of the WAIT
   // cycle that sees ack (>= MAXW means never).
   task automatic do_instr(input logic [5:0] op, input logic [5:0] fn,
                           input logic [31:0] alu, input logic [31:0] rt,
                           input logic [4:0] rd, input logic zero,
                           input int ack_dly, input logic [31:0] rdata);
      bit   done;
      bit   is_mem;
      bit   is_st;
      is_mem = (op == LOAD) || (op == STORE);
      is_st  = (op == STORE);
      ms_i_ce = 1'b1; ms_i_opcode = op; ms_i_funct = fn; ms_i_alu_value = alu;
      ms_i_data_rt = rt; ms_i_rd_addr = rd; ms_i_zero = zero;
      ms_i_mem_ack = 1'b0;
      @(posedge es_clk); @(negedge es_clk);
      m_op = op; m_fn = fn; m_rd = rd; m_zero = zero;
      if (!is_mem) begin
         check("alu_ce",    32'(ms_o_ce), 1);
         check("alu_err",   32'(ms_o_err), 0);
         check("alu_data",  ms_o_data, 0);
         check("alu_req",   32'(ms_o_mem_req), 0);
         check("alu_stall", 32'(ms_o_stall), 0);
         check_fields("alu", alu);
      end else if (alu[1:0] != 2'b00) begin
         check("mis_err",   32'(ms_o_err), 1);
         check("mis_ce",    32'(ms_o_ce), 0);
         check("mis_req",   32'(ms_o_mem_req), 0);
         check("mis_stall", 32'(ms_o_stall), 0);
         check_fields("mis", alu);
      end else begin
         check("acc_req",   32'(ms_o_mem_req), 1);
         check("acc_we",    32'(ms_o_mem_we), 32'(is_st));
         check("acc_addr",  ms_o_mem_addr, alu);
         check("acc_wdata", ms_o_mem_wdata, is_st ? rt : 32'h0);
         check("acc_stall", 32'(ms_o_stall), 1);
         check("acc_ce",    32'(ms_o_ce), 0);
         done = 0;
         for (int k = 0; k < MAXW + 2 && !done; k++) begin
            garbage_inputs();              // stalled: must be ignored
            ms_i_mem_ack   = (k == ack_dly);
            ms_i_mem_rdata = (k == ack_dly) ? rdata : $urandom;
            @(posedge es_clk); @(negedge es_clk);
            ms_i_mem_ack = 1'b0;
            if (k == ack_dly) begin
               check("ack_ce",    32'(ms_o_ce), 1);
               check("ack_err",   32'(ms_o_err), 0);
               check("ack_data",  ms_o_data, is_st ? 32'h0 : rdata);
               check("ack_req",   32'(ms_o_mem_req), 0);
               check("ack_stall", 32'(ms_o_stall), 0);
               check_fields("ack", alu);
               done = 1;
            end else if (k == MAXW - 1) begin
               check("tmo_err",   32'(ms_o_err), 1);
               check("tmo_ce",    32'(ms_o_ce), 0);
               check("tmo_data",  ms_o_data, 0);
               check("tmo_req",   32'(ms_o_mem_req), 0);
               check("tmo_stall", 32'(ms_o_stall), 0);
               done = 1;
            end else begin
               check("wait_req",   32'(ms_o_mem_req), 1);
               check("wait_addr",  ms_o_mem_addr, alu);
               check("wait_we",    32'(ms_o_mem_we), 32'(is_st));
               check("wait_wdata", ms_o_mem_wdata, is_st ? rt : 32'h0);
               check("wait_stall", 32'(ms_o_stall), 1);
               check("wait_ce",    32'(ms_o_ce), 0);
            end
         end
         if (!done) check("wait_bound", 0, 1);
      end
      ms_i_ce = 1'b0;
   endtask

   initial begin
      logic [5:0]  op;
      logic [31:0] a;
      int          kind;
      es_rst = 1'b0;
      ms_i_ce = 0; ms_i_opcode = 0; ms_i_funct = 0; ms_i_alu_value = 0;
      ms_i_zero = 0; ms_i_data_rt = 0; ms_i_rd_addr = 0;
      ms_i_mem_ack = 0; ms_i_mem_rdata = 0;
      m_op = 0; m_fn = 0; m_rd = 0; m_zero = 0;
      repeat (2) @(negedge es_clk);
      check("rst_ce",    32'(ms_o_ce), 0);
      check("rst_err",   32'(ms_o_err), 0);
      check("rst_req",   32'(ms_o_mem_req), 0);
      check("rst_stall", 32'(ms_o_stall), 0);
      check("rst_data",  ms_o_data, 0);
      check("rst_addr",  ms_o_mem_addr, 0);
      check_fields("rst", 32'h0);
      es_rst = 1'b1;

      // directed
      do_instr(RTYPE, 6'h20, 32'h5, 32'h0, 5'd3, 1'b0, 0, 32'h0);
      do_instr(LOAD, 6'h00, 32'h100, 32'h0, 5'd4, 1'b0, 2, 32'hDEADBEEF);
      do_instr(STORE, 6'h00, 32'h204, 32'h12345678, 5'd0, 1'b1, 0, 32'hAAAA5555);
      do_instr(LOAD, 6'h00, 32'h102, 32'h0, 5'd5, 1'b0, 0, 32'h0);
      idle_cycle(1'b1);
      do_instr(LOAD, 6'h00, 32'h300, 32'h0, 5'd6, 1'b0, 99, 32'h0);
      idle_cycle(1'b0);
      do_instr(STORE, 6'h00, 32'h40, 32'hCAFE0001, 5'd7, 1'b0, MAXW - 1, 32'h0);

      // reset during WAIT drops the bus asynchronously
      ms_i_ce = 1'b1; ms_i_opcode = LOAD; ms_i_alu_value = 32'h500;
      @(posedge es_clk); @(negedge es_clk);
      check("pre_rst_req", 32'(ms_o_mem_req), 1);
      #2 es_rst = 1'b0;
      #1;
      check("arst_req",   32'(ms_o_mem_req), 0);
      check("arst_stall", 32'(ms_o_stall), 0);
      check("arst_ce",    32'(ms_o_ce), 0);
      check("arst_addr",  ms_o_mem_addr, 0);
      ms_i_ce = 1'b0;
      m_op = 0; m_fn = 0; m_rd = 0; m_zero = 0;
      @(negedge es_clk);
      es_rst = 1'b1;
      do_instr(RTYPE, 6'h25, 32'h77, 32'h0, 5'd9, 1'b1, 0, 32'h0);

      // randomized
      for (int n = 0; n < 60; n++) begin
         kind = $urandom_range(0, 4);
         a = $urandom & ~32'h3;
         case (kind)
            0: op = 6'($urandom_range(0, 15));
            1: op = LOAD;
            2: op = STORE;
            3: begin
               op = ($urandom_range(0, 1) == 0) ? LOAD : STORE;
               a  = a | 32'($urandom_range(1, 3));
            end
            default: op = 6'($urandom_range(0, 15));
         endcase
         if (kind == 4) idle_cycle(1'($urandom));
         else do_instr(op, 6'($urandom), a, $urandom, 5'($urandom), 1'($urandom),
                       int'($urandom_range(0, MAXW + 1)), $urandom);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

endmodule
